qpu_exu_oitf: RTL and testbench
===============================

// Module: qpu_exu_oitf
// PURPOSE
//  Outstanding Instruction Track FIFO for the QPU EXU. Records every long-pipe
//  instruction the dispatch stage issues (classical rd writers, measure/FMR qubit users).
//  Returns hazard-match flags that dispatch uses to stall RAW/WAW and qubit-flag conflicts.
//  Retires entries in order when the long pipe writes back.
// PARAMETERS
//  OITF_DEPTH  4                      entries; power of two, >=2
//  RFIDX_W     `QPU_RFIDX_REAL_WIDTH  register index width
//  QUBIT_NUM   `QPU_QUBIT_NUM         qubit-list width
//  MEAS_MAX    2                      max measure entries outstanding, <=OITF_DEPTH
// PORTS
//  clk                   in   1          clock
//  rst_n                 in   1          async active-low reset
//  disp_oitf_ena         in   1          allocate a classical long-pipe entry
//  disp_moitf_ena        in   1          allocate a measure entry; one-hot with disp_oitf_ena
//  disp_oitf_ready       out  1          entry free
//  disp_moitf_ready      out  1          entry free and measure count < MEAS_MAX
//  disp_oitf_rs1en       in   1          dispatching instr reads rs1
//  disp_oitf_rs2en       in   1          dispatching instr reads rs2
//  disp_oitf_rdwen       in   1          dispatching instr writes rd
//  disp_oitf_qfren       in   1          dispatching instr uses qubit flags
//  disp_oitf_rs1idx      in   RFIDX_W    rs1 index
//  disp_oitf_rs2idx      in   RFIDX_W    rs2 index
//  disp_oitf_rdidx       in   RFIDX_W    rd index
//  disp_oitf_qubitlist   in   QUBIT_NUM  qubit list
//  oitfrd_match_disprs1  out  1          a valid entry writes disp rs1
//  oitfrd_match_disprs2  out  1          a valid entry writes disp rs2
//  oitfrd_match_disprd   out  1          a valid entry writes disp rd
//  oitfqf_match_dispql   out  1          a valid qfren entry overlaps the disp qubit list
//  oitf_ret_ena          in   1          long pipe retires the oldest entry
//  oitf_ret_rdwen        out  1          oldest entry: rdwen
//  oitf_ret_rdidx        out  RFIDX_W    oldest entry: rdidx
//  oitf_ret_measure      out  1          oldest entry is a measure
//  oitf_ret_qubitlist    out  QUBIT_NUM  oldest entry: qubit list
//  oitf_dis_ptr          out  log2(D)    index the next allocation gets, as tag for ALU
//  oitf_empty            out  1          no valid entries
// BEHAVIOUR
//  - Reset: all valid bits 0; alloc/ret pointers 0; wrap bits 0; meas_cnt 0.
//    Resulting outputs: ready=1, moitf_ready=1 (MEAS_MAX>0), empty=1, all matches 0,
//    ret_* = 0, dis_ptr = 0. Reset mid-operation discards all entries immediately.
//  - Pointers: alloc_ptr and ret_ptr each carry an extra wrap bit.
//    full = (idx equal) & (wrap differ); empty = both equal. Wrap at OITF_DEPTH-1 -> 0
//    toggles the wrap bit.
//  - Alloc = (disp_oitf_ena & disp_oitf_ready) | (disp_moitf_ena & disp_moitf_ready).
//    Writes {rdwen, rdidx, qfren, qubitlist, measure} at alloc_ptr; entry valid next cycle.
//  - ready ignores a same-cycle retire: when full, no alloc occurs even if ret_oitf_ena=1.
//  - Retire on oitf_ret_ena & ~empty: clears the valid bit at ret_ptr and advances ret_ptr.
//    A retire while empty is ignored and flagged by a simulation-only $error.
//  - Same-cycle alloc+retire, not full: both happen; occupancy unchanged.
//  - meas_cnt: +1 on a measure alloc, -1 on a measure retire; both together -> unchanged.
//  - Matches are combinational over entries valid at the start of the cycle.
//    They do not include the same-cycle alloc. A same-cycle retiring entry still matches.
//    rs1 match = rs1en & OR_i(v_i & rdwen_i & rdidx_i==rs1idx); rs2 likewise.
//    rd match  = rdwen & OR_i(v_i & rdwen_i & rdidx_i==rdidx).
//    ql match  = qfren & OR_i(v_i & qfren_i & |(ql_i & qubitlist)).
//  - Index 0 gets no special case; dispatch already masks x0.
//  - ret_* are driven combinationally from the entry at ret_ptr; they are 0 when empty.
//  - Latency: alloc -> match visible 1 cycle; retire -> match cleared 1 cycle.
// STRUCTURE
//  - Shared defines in QPU_defines.v: QPU_OITF_DEPTH, QPU_OITF_MEAS_MAX, and the
//    pointer width macro. Indices and qubit widths stay the existing defines.
//  - One sub-module, qpu_oitf_entry: a single entry register plus its three comparators.
//    Generate OITF_DEPTH copies; the top keeps pointers, meas_cnt and the OR-reduce.
// TESTING
//  1. Reset, then alloc rdidx=5 rdwen=1. Next cycle rs1idx=5, rs1en=1 -> rs1 match=1.
//     rs1en=0 -> match=0.
//  2. Allocate 4 with no retire -> ready=0 after the 4th, empty=0.
//     5th ena ignored; dis_ptr=0 (wrapped).
//  3. Full, then ret_ena with ena same cycle -> no alloc, occupancy 3.
//     Next cycle alloc succeeds.
//  4. Two measures ql=8'b0000_0011 -> moitf_ready=0 while oitf_ready=1.
//     Dispatch ql=8'b0000_0010 qfren=1 -> ql match=1. Retire one -> moitf_ready=1.
//  5. Occupancy 2 with alloc+retire same cycle for 6 cycles -> pointers wrap.
//     Occupancy stays 2 and ret_rdidx follows FIFO order.
//  6. rst_n low with 3 entries valid -> the same cycle gives empty=1, all matches 0.
//     ret_ena while empty -> no pointer change.

Source files
------------

// File: rtl/qpu_exu_oitf_pkg.sv
// ============================================================================
// qpu_exu_oitf_pkg : shared widths and depths for the EXU outstanding-instruction FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

package qpu_exu_oitf_pkg;

    localparam int QPU_RFIDX_REAL_WIDTH = 5;
    localparam int QPU_QUBIT_NUM        = 8;
    localparam int QPU_OITF_DEPTH       = 4;
    localparam int QPU_OITF_MEAS_MAX    = 2;
    localparam int QPU_OITF_PTR_W       = $clog2(QPU_OITF_DEPTH);

    // Counter width able to hold 0..max inclusive.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/qpu_oitf_entry.sv
// ============================================================================
// qpu_oitf_entry : one OITF slot plus its rs1/rs2/rd/qubit-list hazard comparators
// Rev 1.0
// ============================================================================
`default_nettype none

module qpu_oitf_entry
    import qpu_exu_oitf_pkg::*;
#(
    parameter int RFIDX_W   = QPU_RFIDX_REAL_WIDTH,
    parameter int QUBIT_NUM = QPU_QUBIT_NUM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_i,
    input  logic                 clr_i,
    input  logic                 rdwen_i,
    input  logic [RFIDX_W-1:0]   rdidx_i,
    input  logic                 qfren_i,
    input  logic [QUBIT_NUM-1:0] ql_i,
    input  logic                 meas_i,
    input  logic [RFIDX_W-1:0]   cmp_rs1idx_i,
    input  logic [RFIDX_W-1:0]   cmp_rs2idx_i,
    input  logic [RFIDX_W-1:0]   cmp_rdidx_i,
    input  logic [QUBIT_NUM-1:0] cmp_ql_i,
    output logic                 vld_o,
    output logic                 rdwen_o,
    output logic [RFIDX_W-1:0]   rdidx_o,
    output logic                 qfren_o,
    output logic [QUBIT_NUM-1:0] ql_o,
    output logic                 meas_o,
    output logic                 rs1_hit_o,
    output logic                 rs2_hit_o,
    output logic                 rd_hit_o,
    output logic                 ql_hit_o
);

    logic                 vld_q, vld_d;
    logic                 rdwen_q;
    logic [RFIDX_W-1:0]   rdidx_q;
    logic                 qfren_q;
    logic [QUBIT_NUM-1:0] ql_q;
    logic                 meas_q;

    // Set wins over clear; the top never targets one slot with both.
    always_comb begin
        vld_d = vld_q;
        if (set_i)      vld_d = 1'b1;
        else if (clr_i) vld_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            rdwen_q <= 1'b0;
            rdidx_q <= '0;
            qfren_q <= 1'b0;
            ql_q    <= '0;
            meas_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (set_i) begin
                rdwen_q <= rdwen_i;
                rdidx_q <= rdidx_i;
                qfren_q <= qfren_i;
                ql_q    <= ql_i;
                meas_q  <= meas_i;
            end
        end
    end

    assign vld_o     = vld_q;
    assign rdwen_o   = rdwen_q;
    assign rdidx_o   = rdidx_q;
    assign qfren_o   = qfren_q;
    assign ql_o      = ql_q;
    assign meas_o    = meas_q;
    assign rs1_hit_o = vld_q & rdwen_q & (rdidx_q == cmp_rs1idx_i);
    assign rs2_hit_o = vld_q & rdwen_q & (rdidx_q == cmp_rs2idx_i);
    assign rd_hit_o  = vld_q & rdwen_q & (rdidx_q == cmp_rdidx_i);
    assign ql_hit_o  = vld_q & qfren_q & (|(ql_q & cmp_ql_i));

endmodule

`default_nettype wire

// File: rtl/qpu_exu_oitf.sv
// ============================================================================
// qpu_exu_oitf : outstanding instruction track FIFO, hazard matching and in-order retire
// Rev 1.0
// ============================================================================
`default_nettype none

module qpu_exu_oitf
    import qpu_exu_oitf_pkg::*;
#(
    parameter int OITF_DEPTH = QPU_OITF_DEPTH,
    parameter int RFIDX_W    = QPU_RFIDX_REAL_WIDTH,
    parameter int QUBIT_NUM  = QPU_QUBIT_NUM,
    parameter int MEAS_MAX   = QPU_OITF_MEAS_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          disp_oitf_ena,
    input  logic                          disp_moitf_ena,
    output logic                          disp_oitf_ready,
    output logic                          disp_moitf_ready,
    input  logic                          disp_oitf_rs1en,
    input  logic                          disp_oitf_rs2en,
    input  logic                          disp_oitf_rdwen,
    input  logic                          disp_oitf_qfren,
    input  logic [RFIDX_W-1:0]            disp_oitf_rs1idx,
    input  logic [RFIDX_W-1:0]            disp_oitf_rs2idx,
    input  logic [RFIDX_W-1:0]            disp_oitf_rdidx,
    input  logic [QUBIT_NUM-1:0]          disp_oitf_qubitlist,
    output logic                          oitfrd_match_disprs1,
    output logic                          oitfrd_match_disprs2,
    output logic                          oitfrd_match_disprd,
    output logic                          oitfqf_match_dispql,
    input  logic                          oitf_ret_ena,
    output logic                          oitf_ret_rdwen,
    output logic [RFIDX_W-1:0]            oitf_ret_rdidx,
    output logic                          oitf_ret_measure,
    output logic [QUBIT_NUM-1:0]          oitf_ret_qubitlist,
    output logic [$clog2(OITF_DEPTH)-1:0] oitf_dis_ptr,
    output logic                          oitf_empty
);

    localparam int PTR_W = $clog2(OITF_DEPTH);
    localparam int MC_W  = cnt_w(MEAS_MAX);
    localparam logic [MC_W-1:0] MEAS_LIMIT = MC_W'(MEAS_MAX);

    // Pointers carry one extra wrap bit above the slot index.
    logic [PTR_W:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W:0]   ret_ptr_q, ret_ptr_d;
    logic [MC_W-1:0]  meas_cnt_q, meas_cnt_d;

    logic [OITF_DEPTH-1:0] w_vld, w_rdwen, w_qfren, w_meas;
    logic [OITF_DEPTH-1:0] w_rs1_hit, w_rs2_hit, w_rd_hit, w_ql_hit;
    logic [RFIDX_W-1:0]    w_rdidx [OITF_DEPTH];
    logic [QUBIT_NUM-1:0]  w_ql    [OITF_DEPTH];

    logic w_full, w_empty, w_alloc, w_ret;
    logic [PTR_W-1:0] w_alloc_idx, w_ret_idx;

    assign w_alloc_idx = alloc_ptr_q[PTR_W-1:0];
    assign w_ret_idx   = ret_ptr_q[PTR_W-1:0];
    assign w_empty     = (alloc_ptr_q == ret_ptr_q);
    assign w_full      = (w_alloc_idx == w_ret_idx) & (alloc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);

    assign disp_oitf_ready  = ~w_full;
    assign disp_moitf_ready = ~w_full & (meas_cnt_q < MEAS_LIMIT);
    assign w_alloc = (disp_oitf_ena & disp_oitf_ready) | (disp_moitf_ena & disp_moitf_ready);
    assign w_ret   = oitf_ret_ena & ~w_empty;

    generate
        for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_entry
            qpu_oitf_entry #(
                .RFIDX_W   (RFIDX_W),
                .QUBIT_NUM (QUBIT_NUM)
            ) u_entry (
                .clk          (clk),
                .rst_n        (rst_n),
                .set_i        (w_alloc & (w_alloc_idx == PTR_W'(i))),
                .clr_i        (w_ret & (w_ret_idx == PTR_W'(i))),
                .rdwen_i      (disp_oitf_rdwen),
                .rdidx_i      (disp_oitf_rdidx),
                .qfren_i      (disp_oitf_qfren),
                .ql_i         (disp_oitf_qubitlist),
                .meas_i       (disp_moitf_ena),
                .cmp_rs1idx_i (disp_oitf_rs1idx),
                .cmp_rs2idx_i (disp_oitf_rs2idx),
                .cmp_rdidx_i  (disp_oitf_rdidx),
                .cmp_ql_i     (disp_oitf_qubitlist),
                .vld_o        (w_vld[i]),
                .rdwen_o      (w_rdwen[i]),
                .rdidx_o      (w_rdidx[i]),
                .qfren_o      (w_qfren[i]),
                .ql_o         (w_ql[i]),
                .meas_o       (w_meas[i]),
                .rs1_hit_o    (w_rs1_hit[i]),
                .rs2_hit_o    (w_rs2_hit[i]),
                .rd_hit_o     (w_rd_hit[i]),
                .ql_hit_o     (w_ql_hit[i])
            );
        end
    endgenerate

    assign oitfrd_match_disprs1 = disp_oitf_rs1en & (|w_rs1_hit);
    assign oitfrd_match_disprs2 = disp_oitf_rs2en & (|w_rs2_hit);
    assign oitfrd_match_disprd  = disp_oitf_rdwen & (|w_rd_hit);
    assign oitfqf_match_dispql  = disp_oitf_qfren & (|w_ql_hit);

    always_comb begin
        oitf_ret_rdwen     = 1'b0;
        oitf_ret_rdidx     = '0;
        oitf_ret_measure   = 1'b0;
        oitf_ret_qubitlist = '0;
        if (!w_empty) begin
            oitf_ret_rdwen     = w_rdwen[w_ret_idx];
            oitf_ret_rdidx     = w_rdidx[w_ret_idx];
            oitf_ret_measure   = w_meas[w_ret_idx];
            oitf_ret_qubitlist = w_ql[w_ret_idx];
        end
    end

    // Power-of-two depth: a plain increment carries into the wrap bit.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        meas_cnt_d  = meas_cnt_q;
        if (w_alloc) alloc_ptr_d = alloc_ptr_q + (PTR_W+1)'(1);
        if (w_ret)   ret_ptr_d   = ret_ptr_q + (PTR_W+1)'(1);
        case ({w_alloc & disp_moitf_ena, w_ret & oitf_ret_measure})
            2'b10:   meas_cnt_d = meas_cnt_q + MC_W'(1);
            2'b01:   meas_cnt_d = meas_cnt_q - MC_W'(1);
            default: meas_cnt_d = meas_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
            meas_cnt_q  <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            meas_cnt_q  <= meas_cnt_d;
        end
    end

    assign oitf_dis_ptr = w_alloc_idx;
    assign oitf_empty   = w_empty;

`ifdef QPU_OITF_SIM_CHECKS
    always_ff @(posedge clk) begin
        if (rst_n && oitf_ret_ena && w_empty)
            $error("qpu_exu_oitf: retire requested while empty");
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_qpu_exu_oitf.sv
// ============================================================================
// tb_qpu_exu_oitf : directed and random checks of the OITF against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_qpu_exu_oitf;

    localparam int DEPTH = 4;
    localparam int MMAX  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, mena, ret_ena, rs1en, rs2en, rdwen, qfren;
    logic [4:0] rs1idx, rs2idx, rdidx;
    logic [7:0] ql;
    logic       ready, mready, m1, m2, mrd, mql;
    logic       r_rdwen, r_meas, empty;
    logic [4:0] r_rdidx;
    logic [7:0] r_ql;
    logic [1:0] dis_ptr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qpu_exu_oitf dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .disp_oitf_ena        (ena),
        .disp_moitf_ena       (mena),
        .disp_oitf_ready      (ready),
        .disp_moitf_ready     (mready),
        .disp_oitf_rs1en      (rs1en),
        .disp_oitf_rs2en      (rs2en),
        .disp_oitf_rdwen      (rdwen),
        .disp_oitf_qfren      (qfren),
        .disp_oitf_rs1idx     (rs1idx),
        .disp_oitf_rs2idx     (rs2idx),
        .disp_oitf_rdidx      (rdidx),
        .disp_oitf_qubitlist  (ql),
        .oitfrd_match_disprs1 (m1),
        .oitfrd_match_disprs2 (m2),
        .oitfrd_match_disprd  (mrd),
        .oitfqf_match_dispql  (mql),
        .oitf_ret_ena         (ret_ena),
        .oitf_ret_rdwen       (r_rdwen),
        .oitf_ret_rdidx       (r_rdidx),
        .oitf_ret_measure     (r_meas),
        .oitf_ret_qubitlist   (r_ql),
        .oitf_dis_ptr         (dis_ptr),
        .oitf_empty           (empty)
    );

    // Reference model: in-order list of outstanding instructions.
    typedef struct packed {
        logic       rdwen;
        logic [4:0] rdidx;
        logic       qfren;
        logic [7:0] ql;
        logic       meas;
    } ent_t;

    ent_t mq[$];
    int   alloc_cnt = 0;

    logic       e_ready, e_mready, e_empty, e_m1, e_m2, e_mrd, e_mql;
    logic       e_rdwen, e_meas;
    logic [4:0] e_rdidx;
    logic [7:0] e_ql;
    logic [1:0] e_dis;

    function automatic void model_eval();
        int mc = 0;
        e_m1 = 0; e_m2 = 0; e_mrd = 0; e_mql = 0;
        foreach (mq[i]) begin
            if (mq[i].meas) mc++;
            if (rs1en && mq[i].rdwen && mq[i].rdidx == rs1idx) e_m1 = 1;
            if (rs2en && mq[i].rdwen && mq[i].rdidx == rs2idx) e_m2 = 1;
            if (rdwen && mq[i].rdwen && mq[i].rdidx == rdidx)  e_mrd = 1;
            if (qfren && mq[i].qfren && ((mq[i].ql & ql) != 0)) e_mql = 1;
        end
        e_ready  = mq.size() < DEPTH;
        e_mready = e_ready && (mc < MMAX);
        e_empty  = mq.size() == 0;
        e_rdwen  = e_empty ? 1'b0 : mq[0].rdwen;
        e_rdidx  = e_empty ? 5'd0 : mq[0].rdidx;
        e_meas   = e_empty ? 1'b0 : mq[0].meas;
        e_ql     = e_empty ? 8'd0 : mq[0].ql;
        e_dis    = 2'(alloc_cnt % DEPTH);
    endfunction

    task automatic idle();
        ena = 0; mena = 0; ret_ena = 0; rs1en = 0; rs2en = 0; rdwen = 0; qfren = 0;
        rs1idx = 0; rs2idx = 0; rdidx = 0; ql = 0;
    endtask

    // Advance one clock edge, keeping the model in step with the applied inputs.
    task automatic step();
        bit da, dr;
        model_eval();
        da = (ena && e_ready) || (mena && e_mready);
        dr = ret_ena && !e_empty;
        @(posedge clk);
        if (dr) void'(mq.pop_front());
        if (da) begin
            mq.push_back('{rdwen, rdidx, qfren, ql, mena});
            alloc_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        mq.delete();
        alloc_cnt = 0;
        #1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        mq.delete();
        alloc_cnt = 0;
        #2;
        checks++;
        if ({ready, mready, empty, dis_ptr} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_status got=%b exp=11100", {ready, mready, empty, dis_ptr});
        end
        checks++;
        if ({m1, m2, mrd, mql, r_rdwen, r_rdidx, r_meas, r_ql} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {m1, m2, mrd, mql, r_rdwen, r_rdidx, r_meas, r_ql});
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_rs1_match();
        @(negedge clk);
        idle(); ena = 1; rdwen = 1; rdidx = 5;
        step();
        @(negedge clk);
        idle(); rs1en = 1; rs1idx = 5;
        #1;
        checks++;
        if (m1 !== 1'b1) begin failures++; $display("FAIL rs1_match got=%b exp=1", m1); end
        rs1en = 0;
        #1;
        checks++;
        if (m1 !== 1'b0) begin failures++; $display("FAIL rs1_nomatch got=%b exp=0", m1); end
        step();
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            idle(); ena = 1; rdwen = 1; rdidx = 5'(10 + i);
            step();
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({ready, empty, dis_ptr} !== 4'b0000) begin
            failures++;
            $display("FAIL full_status got=%b exp=0000", {ready, empty, dis_ptr});
        end
        ena = 1; rdwen = 1; rdidx = 5'd30;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({ready, dis_ptr, r_rdidx} !== {1'b0, 2'd0, 5'd10}) begin
            failures++;
            $display("FAIL full_ignore got=%h exp=%h", {ready, dis_ptr, r_rdidx}, {1'b0, 2'd0, 5'd10});
        end
    endtask

    task automatic test_full_retire();
        @(negedge clk);
        idle(); ena = 1; rdwen = 1; rdidx = 5'd20; ret_ena = 1;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({ready, dis_ptr, r_rdidx} !== {1'b1, 2'd0, 5'd11}) begin
            failures++;
            $display("FAIL full_ret_noalloc got=%h exp=%h", {ready, dis_ptr, r_rdidx}, {1'b1, 2'd0, 5'd11});
        end
        ena = 1; rdwen = 1; rdidx = 5'd21;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({ready, dis_ptr} !== {1'b0, 2'd1}) begin
            failures++;
            $display("FAIL full_ret_alloc got=%b exp=001", {ready, dis_ptr});
        end
    endtask

    task automatic test_measure();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle(); mena = 1; qfren = 1; ql = 8'b0000_0011;
            step();
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({mready, ready} !== 2'b01) begin
            failures++;
            $display("FAIL meas_limit got=%b exp=01", {mready, ready});
        end
        qfren = 1; ql = 8'b0000_0010;
        #1;
        checks++;
        if (mql !== 1'b1) begin failures++; $display("FAIL ql_match got=%b exp=1", mql); end
        ql = 8'b1000_0100;
        #1;
        checks++;
        if (mql !== 1'b0) begin failures++; $display("FAIL ql_disjoint got=%b exp=0", mql); end
        idle(); ret_ena = 1;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({mready, r_meas} !== 2'b11) begin
            failures++;
            $display("FAIL meas_release got=%b exp=11", {mready, r_meas});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle(); ena = 1; rdwen = 1; rdidx = 5'(i + 1);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle(); ena = 1; ret_ena = 1; rdwen = 1; rdidx = 5'($urandom_range(0, 31));
            #1;
            model_eval();
            checks++;
            if ({ready, empty, r_rdidx} !== {2'b10, e_rdidx}) begin
                failures++;
                $display("FAIL b2b_order got=%h exp=%h", {ready, empty, r_rdidx}, {2'b10, e_rdidx});
            end
            step();
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({dis_ptr, empty, ready} !== {2'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_wrap got=%b exp=0001", {dis_ptr, empty, ready});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(); ena = 1; rdwen = 1; qfren = 1; ql = 8'hFF; rdidx = 5'(7 + i);
            step();
        end
        @(negedge clk);
        idle(); rs1en = 1; rs1idx = 7; rs2en = 1; rs2idx = 8; rdwen = 1; rdidx = 9; qfren = 1; ql = 8'hFF;
        #2;
        rst_n = 0;
        mq.delete();
        alloc_cnt = 0;
        #1;
        checks++;
        if ({empty, m1, m2, mrd, mql} !== 5'b10000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=10000", {empty, m1, m2, mrd, mql});
        end
        @(negedge clk);
        rst_n = 1;
        idle(); ret_ena = 1;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({empty, dis_ptr} !== 3'b100) begin
            failures++;
            $display("FAIL empty_retire got=%b exp=100", {empty, dis_ptr});
        end
        ena = 1; rdwen = 1; rdidx = 5'd9;
        step();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({empty, r_rdidx, dis_ptr} !== {1'b0, 5'd9, 2'd1}) begin
            failures++;
            $display("FAIL empty_retire_ptr got=%h exp=%h", {empty, r_rdidx, dis_ptr}, {1'b0, 5'd9, 2'd1});
        end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            op      = int'($urandom_range(0, 3));
            ena     = (op == 1);
            mena    = (op == 2);
            ret_ena = ($urandom_range(0, 2) == 0);
            rs1en   = 1'($urandom); rs2en = 1'($urandom);
            rdwen   = 1'($urandom); qfren = 1'($urandom);
            rs1idx  = 5'($urandom_range(0, 7));
            rs2idx  = 5'($urandom_range(0, 7));
            rdidx   = 5'($urandom_range(0, 7));
            ql      = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
            #1;
            model_eval();
            checks++;
            if ({ready, mready, empty, dis_ptr} !== {e_ready, e_mready, e_empty, e_dis}) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got=%b exp=%b", n,
                         {ready, mready, empty, dis_ptr}, {e_ready, e_mready, e_empty, e_dis});
            end
            checks++;
            if ({m1, m2, mrd, mql} !== {e_m1, e_m2, e_mrd, e_mql}) begin
                failures++;
                $display("FAIL rnd_match cyc=%0d got=%b exp=%b", n,
                         {m1, m2, mrd, mql}, {e_m1, e_m2, e_mrd, e_mql});
            end
            checks++;
            if ({r_rdwen, r_rdidx, r_meas, r_ql} !== {e_rdwen, e_rdidx, e_meas, e_ql}) begin
                failures++;
                $display("FAIL rnd_ret cyc=%0d got=%h exp=%h", n,
                         {r_rdwen, r_rdidx, r_meas, r_ql}, {e_rdwen, e_rdidx, e_meas, e_ql});
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rs1_match();
        test_full();
        test_full_retire();
        test_measure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
